l1_mem_responder: RTL and testbench

L1_MEM_RESPONDER -- requirements
Module: l1_mem_responder

---
 rtl/l1_mem_responder_pkg.sv | 43 ++++
 rtl/l1_mem_responder_if.sv | 47 ++++
 rtl/l1_mem_responder_mmio_addr.sv | 16 +
 rtl/l1_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_l1_mem_responder.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1_mem_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | l1_mem_responder_pkg : shared types, sizes and helpers for the responder  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package l1_mem_responder_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_BURST = 3'd1,
    WR_BURST = 3'd2,
    MMIO     = 3'd3,
    DONE     = 3'd4,
    GAP      = 3'd5
  } state_e;

  localparam int LINE_WORDS     = 8;
  localparam int WORD_OFF_BITS  = 3;
  localparam int WORD_BITS      = 32;
  localparam int LINE_BITS      = LINE_WORDS * WORD_BITS;
  localparam int LINE_ADDR_BITS = 32 - WORD_OFF_BITS - 2;

  localparam logic [WORD_OFF_BITS-1:0] LAST_BEAT = WORD_OFF_BITS'(LINE_WORDS - 1);

  localparam logic [7:0]  MMIO_TIMEOUT  = 8'd255;
  localparam logic [31:0] MMIO_ERR_DATA = 32'hDEADBEEF;

  // Uncached window: any address whose top nibble is 0xF
  localparam logic [31:0] MMIO_MASK = 32'hF000_0000;
  localparam logic [31:0] MMIO_BASE = 32'hF000_0000;

  function automatic logic [31:0] beat_addr(input logic [LINE_ADDR_BITS-1:0] line,
                                            input logic [WORD_OFF_BITS-1:0]  k);
    return {line, k, 2'b00};
  endfunction

  function automatic logic [WORD_BITS-1:0] line_word(input logic [LINE_BITS-1:0]     line,
                                                     input logic [WORD_OFF_BITS-1:0] k);
    return line[{k, 5'b0} +: WORD_BITS];
  endfunction

endpackage
`default_nettype wire

// File: rtl/l1_mem_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | l1_mem_responder_if : L1 request, backing RAM and MMIO signal bundle      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface l1_mem_responder_if;
  import l1_mem_responder_pkg::*;

  logic                 l1_mmu_req_read;
  logic                 l1_mmu_req_write;
  logic [31:0]          l1_mmu_req_addr;
  logic [LINE_BITS-1:0] l1_mmu_write_data;
  logic                 mmu_l1_done;
  logic [LINE_BITS-1:0] mmu_l1_read_data;

  logic [31:0]          mem_addr;
  logic                 mem_we;
  logic [31:0]          mem_wdata;
  logic [31:0]          mem_rdata;

  logic                 mmio_req;
  logic                 mmio_we;
  logic [31:0]          mmio_addr;
  logic [31:0]          mmio_wdata;
  logic [31:0]          mmio_rdata;
  logic                 mmio_ack;

  modport slave (
    input  l1_mmu_req_read, l1_mmu_req_write, l1_mmu_req_addr, l1_mmu_write_data,
    output mmu_l1_done, mmu_l1_read_data,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output mmio_req, mmio_we, mmio_addr, mmio_wdata,
    input  mmio_rdata, mmio_ack
  );

  modport master (
    output l1_mmu_req_read, l1_mmu_req_write, l1_mmu_req_addr, l1_mmu_write_data,
    input  mmu_l1_done, mmu_l1_read_data,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  mmio_req, mmio_we, mmio_addr, mmio_wdata,
    output mmio_rdata, mmio_ack
  );

endinterface
`default_nettype wire

// File: rtl/l1_mem_responder_mmio_addr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mmio_addr : classifies a full byte address as MMIO or cacheable          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module mmio_addr
  import l1_mem_responder_pkg::*;
(
  input  logic [31:0] addr_i,
  output logic        is_mmio_o
);

  assign is_mmio_o = ((addr_i & MMIO_MASK) == MMIO_BASE);

endmodule
`default_nettype wire

// File: rtl/l1_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | l1_mem_responder : serves L1 line refills/writebacks over a word RAM and  |
// | single-word MMIO. Optional MMIO_TIMEOUT_EN adds an MMIO ack watchdog.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module l1_mem_responder
  import l1_mem_responder_pkg::*;
(
  input  logic              sys_clk,
  input  logic              rst_n,
  l1_mem_responder_if.slave bus
);

  state_e                    state_q;
  logic [WORD_OFF_BITS-1:0]  cnt_q;
  logic                      drain_q;
  logic [LINE_ADDR_BITS-1:0] line_q;
  logic [LINE_BITS-1:0]      buf_q;
  logic [LINE_BITS-1:0]      rdata_q;
  logic                      done_q;
  logic [31:0]               mem_addr_q;
  logic                      mem_we_q;
  logic [31:0]               mem_wdata_q;
  logic                      mmio_req_q;
  logic                      mmio_we_q;
  logic [31:0]               mmio_addr_q;
  logic [31:0]               mmio_wdata_q;
`ifdef MMIO_TIMEOUT_EN
  logic [7:0]                to_cnt_q;
`endif

  logic                      w_is_mmio;
  logic [WORD_OFF_BITS-1:0]  w_cnt_inc;
  logic [WORD_OFF_BITS-1:0]  w_cnt_prev;

  mmio_addr u_mmio_addr (
    .addr_i    (bus.l1_mmu_req_addr),
    .is_mmio_o (w_is_mmio)
  );

  assign w_cnt_inc  = cnt_q + 1'b1;
  assign w_cnt_prev = cnt_q - 1'b1;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      drain_q      <= 1'b0;
      line_q       <= '0;
      buf_q        <= '0;
      rdata_q      <= '0;
      done_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      mmio_req_q   <= 1'b0;
      mmio_we_q    <= 1'b0;
      mmio_addr_q  <= '0;
      mmio_wdata_q <= '0;
`ifdef MMIO_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q   <= '0;
          drain_q <= 1'b0;
`ifdef MMIO_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
          if (bus.l1_mmu_req_write || bus.l1_mmu_req_read) begin
            if (w_is_mmio) begin
              state_q      <= MMIO;
              mmio_req_q   <= 1'b1;
              mmio_we_q    <= bus.l1_mmu_req_write;
              mmio_addr_q  <= bus.l1_mmu_req_addr;
              mmio_wdata_q <= bus.l1_mmu_write_data[31:0];
            end else begin
              line_q     <= bus.l1_mmu_req_addr[31:5];
              mem_addr_q <= beat_addr(bus.l1_mmu_req_addr[31:5], '0);
              // Writeback wins so a dirty victim leaves before its refill
              if (bus.l1_mmu_req_write) begin
                state_q     <= WR_BURST;
                mem_we_q    <= 1'b1;
                mem_wdata_q <= line_word(bus.l1_mmu_write_data, '0);
              end else begin
                state_q <= RD_BURST;
              end
            end
          end
        end

        RD_BURST: begin
          // RAM data lags the address by one cycle, so capture trails by one beat
          if (!drain_q) begin
            if (cnt_q != '0) begin
              buf_q[{w_cnt_prev, 5'b0} +: WORD_BITS] <= bus.mem_rdata;
            end
            if (cnt_q == LAST_BEAT) begin
              drain_q <= 1'b1;
            end else begin
              cnt_q      <= w_cnt_inc;
              mem_addr_q <= beat_addr(line_q, w_cnt_inc);
            end
          end else begin
            buf_q[LINE_BITS-1 -: WORD_BITS] <= bus.mem_rdata;
            rdata_q <= {bus.mem_rdata, buf_q[LINE_BITS-WORD_BITS-1:0]};
            drain_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end

        WR_BURST: begin
          if (cnt_q == LAST_BEAT) begin
            mem_we_q <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q       <= w_cnt_inc;
            mem_addr_q  <= beat_addr(line_q, w_cnt_inc);
            mem_wdata_q <= line_word(bus.l1_mmu_write_data, w_cnt_inc);
          end
        end

        MMIO: begin
          if (bus.mmio_ack) begin
            mmio_req_q <= 1'b0;
            rdata_q    <= mmio_we_q ? '0 : {{(LINE_BITS-WORD_BITS){1'b0}}, bus.mmio_rdata};
            done_q     <= 1'b1;
            state_q    <= DONE;
          end
`ifdef MMIO_TIMEOUT_EN
          else if (to_cnt_q == MMIO_TIMEOUT - 8'd1) begin
            mmio_req_q <= 1'b0;
            rdata_q    <= {{(LINE_BITS-WORD_BITS){1'b0}}, MMIO_ERR_DATA};
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else begin
            to_cnt_q <= to_cnt_q + 8'd1;
          end
`endif
        end

        DONE: begin
          done_q  <= 1'b0;
          state_q <= GAP;
        end

        // Requester still holds its request this cycle; let it fall first
        GAP: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mmu_l1_done      = done_q;
  assign bus.mmu_l1_read_data = rdata_q;
  assign bus.mem_addr         = mem_addr_q;
  assign bus.mem_we           = mem_we_q;
  assign bus.mem_wdata        = mem_wdata_q;
  assign bus.mmio_req         = mmio_req_q;
  assign bus.mmio_we          = mmio_we_q;
  assign bus.mmio_addr        = mmio_addr_q;
  assign bus.mmio_wdata       = mmio_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_l1_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_l1_mem_responder : scoreboard bench for l1_mem_responder              |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_l1_mem_responder;
  import l1_mem_responder_pkg::*;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   total   = 0;
  int   bad     = 0;
  int   cyc     = 0;

  l1_mem_responder_if bus();

  l1_mem_responder dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  logic [31:0]  ram [logic [31:0]];
  logic [63:0]  act_wr[$];
  logic [63:0]  exp_wr[$];
  logic [255:0] exp_rd[$];
  logic [255:0] last_rd;

  // Unwritten RAM words hold a pattern giving 0x1000+i for the line at 0x1020
  function automatic logic [31:0] ram_init(input logic [31:0] a);
    return 32'h1000 + ((a - 32'h1020) >> 2);
  endfunction

  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    bus.mem_rdata <= ram.exists(bus.mem_addr) ? ram[bus.mem_addr] : ram_init(bus.mem_addr);
    if (bus.mem_we === 1'b1) begin
      ram[bus.mem_addr] = bus.mem_wdata;
      act_wr.push_back({bus.mem_addr, bus.mem_wdata});
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    total++; if (bus.mmu_l1_done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", bus.mmu_l1_done); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got %b want 0", bus.mem_we); end
    total++; if (bus.mmio_req !== 1'b0) begin bad++; $display("FAIL reset_mmio_req got %b want 0", bus.mmio_req); end
    total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
    total++; if (bus.mmu_l1_read_data !== 256'h0) begin bad++; $display("FAIL reset_read_data got %h want 0", bus.mmu_l1_read_data); end
    rst_n   = 1'b1;
    last_rd = '0;
    @(negedge sys_clk);
  endtask

  task automatic test_refill();
    logic [255:0] line, exp;
    int t0, done_at;
    for (int i = 0; i < 8; i++) line[32*i +: 32] = 32'h1000 + i;
    exp_rd.push_back(line);
    @(negedge sys_clk);
    t0 = cyc; done_at = -1;
    bus.l1_mmu_req_read = 1'b1; bus.l1_mmu_req_addr = 32'h0000_1020;
    for (int n = 1; n <= 20 && done_at < 0; n++) begin
      @(negedge sys_clk);
      if (n <= 8) begin
        total++;
        if (bus.mem_addr !== 32'h1020 + 32'(4*(n-1))) begin
          bad++; $display("FAIL refill_addr beat %0d got %h want %h", n-1, bus.mem_addr, 32'h1020 + 32'(4*(n-1)));
        end
      end
      if (bus.mmu_l1_done === 1'b1) begin done_at = cyc - t0; bus.l1_mmu_req_read = 1'b0; end
    end
    bus.l1_mmu_req_read = 1'b0;
    exp = exp_rd.pop_front();
    total++; if (done_at != 10) begin bad++; $display("FAIL refill_latency got %0d want 10", done_at); end
    total++; if (bus.mmu_l1_read_data !== exp) begin bad++; $display("FAIL refill_data got %h want %h", bus.mmu_l1_read_data, exp); end
    last_rd = exp;
    @(negedge sys_clk);
    total++; if (bus.mmu_l1_done !== 1'b0) begin bad++; $display("FAIL refill_done_width got %b want 0", bus.mmu_l1_done); end
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_writeback();
    logic [255:0] wl;
    logic [63:0]  a, e;
    int t0, done_at;
    act_wr.delete(); exp_wr.delete();
    for (int i = 0; i < 8; i++) begin
      wl[32*i +: 32] = 32'hA0 + i;
      exp_wr.push_back({32'h2040 + 32'(4*i), 32'hA0 + 32'(i)});
    end
    @(negedge sys_clk);
    t0 = cyc; done_at = -1;
    bus.l1_mmu_req_write = 1'b1; bus.l1_mmu_req_addr = 32'h0000_2040; bus.l1_mmu_write_data = wl;
    for (int n = 1; n <= 20 && done_at < 0; n++) begin
      @(negedge sys_clk);
      if (n <= 8) begin
        total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL wb_we beat %0d got %b want 1", n-1, bus.mem_we); end
      end
      if (bus.mmu_l1_done === 1'b1) begin done_at = cyc - t0; bus.l1_mmu_req_write = 1'b0; end
    end
    bus.l1_mmu_req_write = 1'b0;
    total++; if (done_at != 9) begin bad++; $display("FAIL wb_latency got %0d want 9", done_at); end
    total++; if (bus.mmu_l1_read_data !== last_rd) begin bad++; $display("FAIL wb_read_data_kept got %h want %h", bus.mmu_l1_read_data, last_rd); end
    total++; if (act_wr.size() != 8) begin bad++; $display("FAIL wb_beats got %0d want 8", act_wr.size()); end
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      a = (act_wr.size() > 0) ? act_wr.pop_front() : 64'hx;
      total++; if (a !== e) begin bad++; $display("FAIL wb_beat got %h want %h", a, e); end
    end
    @(negedge sys_clk);
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL wb_we_after got %b want 0", bus.mem_we); end
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_back_to_back();
    logic [255:0] wl, exp;
    int t0, d1, d2;
    act_wr.delete();
    for (int i = 0; i < 8; i++) wl[32*i +: 32] = 32'hB0 + i;
    exp_rd.push_back(wl);
    @(negedge sys_clk);
    t0 = cyc; d1 = -1; d2 = -1;
    bus.l1_mmu_req_read = 1'b1; bus.l1_mmu_req_write = 1'b1;
    bus.l1_mmu_req_addr = 32'h0000_3000; bus.l1_mmu_write_data = wl;
    for (int n = 1; n <= 40 && d2 < 0; n++) begin
      @(negedge sys_clk);
      if (bus.mmu_l1_done === 1'b1) begin
        if (d1 < 0) begin
          d1 = cyc - t0; bus.l1_mmu_req_write = 1'b0;
          total++; if (bus.mmu_l1_read_data !== last_rd) begin bad++; $display("FAIL b2b_first_data got %h want %h", bus.mmu_l1_read_data, last_rd); end
          total++; if (act_wr.size() != 8) begin bad++; $display("FAIL b2b_write_first got %0d beats want 8", act_wr.size()); end
        end else begin
          d2 = cyc - t0; bus.l1_mmu_req_read = 1'b0;
        end
      end
    end
    bus.l1_mmu_req_read = 1'b0; bus.l1_mmu_req_write = 1'b0;
    exp = exp_rd.pop_front();
    total++; if (d1 != 9) begin bad++; $display("FAIL b2b_first_done got %0d want 9", d1); end
    total++; if (d2 != 21) begin bad++; $display("FAIL b2b_second_done got %0d want 21", d2); end
    total++; if (bus.mmu_l1_read_data !== exp) begin bad++; $display("FAIL b2b_read_data got %h want %h", bus.mmu_l1_read_data, exp); end
    last_rd = exp;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_mmio();
    logic [255:0] exp;
    bit seen, early;
    exp_rd.push_back({224'b0, 32'h55});
    @(negedge sys_clk);
    bus.l1_mmu_req_read = 1'b1; bus.l1_mmu_req_addr = 32'hF000_0010;
    seen = 1'b0; early = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge sys_clk);
      if (bus.mmio_req === 1'b1) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL mmio_req got 0 want 1"); end
    total++; if (bus.mmio_addr !== 32'hF000_0010) begin bad++; $display("FAIL mmio_addr got %h want f0000010", bus.mmio_addr); end
    total++; if (bus.mmio_we !== 1'b0) begin bad++; $display("FAIL mmio_we_rd got %b want 0", bus.mmio_we); end
    repeat (4) begin
      @(negedge sys_clk);
      if (bus.mmu_l1_done !== 1'b0 || bus.mmio_req !== 1'b1) early = 1'b1;
    end
    total++; if (early) begin bad++; $display("FAIL mmio_wait got early done/req drop want hold"); end
    bus.mmio_ack = 1'b1; bus.mmio_rdata = 32'h55;
    @(negedge sys_clk);
    bus.mmio_ack = 1'b0; bus.mmio_rdata = 32'h0; bus.l1_mmu_req_read = 1'b0;
    exp = exp_rd.pop_front();
    total++; if (bus.mmu_l1_done !== 1'b1) begin bad++; $display("FAIL mmio_done got %b want 1", bus.mmu_l1_done); end
    total++; if (bus.mmio_req !== 1'b0) begin bad++; $display("FAIL mmio_req_drop got %b want 0", bus.mmio_req); end
    total++; if (bus.mmu_l1_read_data !== exp) begin bad++; $display("FAIL mmio_rdata got %h want %h", bus.mmu_l1_read_data, exp); end
    last_rd = exp;
    @(negedge sys_clk);
    total++; if (bus.mmu_l1_done !== 1'b0) begin bad++; $display("FAIL mmio_done_width got %b want 0", bus.mmu_l1_done); end
    @(negedge sys_clk);
    total++; if (bus.mmu_l1_done !== 1'b0 || bus.mmio_req !== 1'b0) begin bad++; $display("FAIL mmio_gap got done=%b req=%b want 0/0", bus.mmu_l1_done, bus.mmio_req); end

    // MMIO write: strobe carries write flag and low data word
    @(negedge sys_clk);
    bus.l1_mmu_req_write = 1'b1; bus.l1_mmu_req_addr = 32'hF000_0020;
    bus.l1_mmu_write_data = {224'b0, 32'h77};
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge sys_clk);
      if (bus.mmio_req === 1'b1) seen = 1'b1;
    end
    total++; if (!seen || bus.mmio_we !== 1'b1) begin bad++; $display("FAIL mmio_wr_req got req=%b we=%b want 1/1", seen, bus.mmio_we); end
    total++; if (bus.mmio_wdata !== 32'h77) begin bad++; $display("FAIL mmio_wdata got %h want 77", bus.mmio_wdata); end
    bus.mmio_ack = 1'b1;
    @(negedge sys_clk);
    bus.mmio_ack = 1'b0; bus.l1_mmu_req_write = 1'b0;
    total++; if (bus.mmu_l1_done !== 1'b1) begin bad++; $display("FAIL mmio_wr_done got %b want 1", bus.mmu_l1_done); end
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_reset_mid_burst();
    logic [255:0] wl, line, exp;
    bit spurious;
    int t0, done_at;
    // Refill interrupted at cycle 4
    @(negedge sys_clk);
    bus.l1_mmu_req_read = 1'b1; bus.l1_mmu_req_addr = 32'h0000_1020;
    repeat (4) @(negedge sys_clk);
    rst_n = 1'b0; bus.l1_mmu_req_read = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1;
    total++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mid_outputs got we=%b addr=%h want 0/0", bus.mem_we, bus.mem_addr); end
    total++; if (bus.mmu_l1_read_data !== 256'h0) begin bad++; $display("FAIL rst_mid_read_data got %h want 0", bus.mmu_l1_read_data); end
    last_rd = '0;
    spurious = 1'b0;
    repeat (12) begin
      @(negedge sys_clk);
      if (bus.mmu_l1_done !== 1'b0 || bus.mem_we !== 1'b0) spurious = 1'b1;
    end
    total++; if (spurious) begin bad++; $display("FAIL rst_mid_quiet got activity want none"); end

    // Writeback interrupted at cycle 4: only four beats reach RAM
    act_wr.delete();
    for (int i = 0; i < 8; i++) wl[32*i +: 32] = 32'hC0 + i;
    @(negedge sys_clk);
    bus.l1_mmu_req_write = 1'b1; bus.l1_mmu_req_addr = 32'h0000_2040; bus.l1_mmu_write_data = wl;
    repeat (4) @(negedge sys_clk);
    rst_n = 1'b0; bus.l1_mmu_req_write = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1;
    spurious = 1'b0;
    repeat (12) begin
      @(negedge sys_clk);
      if (bus.mmu_l1_done !== 1'b0) spurious = 1'b1;
    end
    total++; if (act_wr.size() != 4) begin bad++; $display("FAIL rst_mid_wb_beats got %0d want 4", act_wr.size()); end
    total++; if (spurious) begin bad++; $display("FAIL rst_mid_wb_done got pulse want none"); end

    // A fresh refill after reset completes normally
    for (int i = 0; i < 8; i++) line[32*i +: 32] = 32'h1000 + i;
    exp_rd.push_back(line);
    @(negedge sys_clk);
    t0 = cyc; done_at = -1;
    bus.l1_mmu_req_read = 1'b1; bus.l1_mmu_req_addr = 32'h0000_1020;
    for (int n = 1; n <= 20 && done_at < 0; n++) begin
      @(negedge sys_clk);
      if (bus.mmu_l1_done === 1'b1) begin done_at = cyc - t0; bus.l1_mmu_req_read = 1'b0; end
    end
    bus.l1_mmu_req_read = 1'b0;
    exp = exp_rd.pop_front();
    total++; if (done_at != 10) begin bad++; $display("FAIL rst_after_latency got %0d want 10", done_at); end
    total++; if (bus.mmu_l1_read_data !== exp) begin bad++; $display("FAIL rst_after_data got %h want %h", bus.mmu_l1_read_data, exp); end
    last_rd = exp;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_mmio_timeout();
    int t0, done_at;
    @(negedge sys_clk);
    t0 = cyc; done_at = -1;
    bus.l1_mmu_req_read = 1'b1; bus.l1_mmu_req_addr = 32'hF000_0030;
`ifdef MMIO_TIMEOUT_EN
    for (int n = 1; n <= 300 && done_at < 0; n++) begin
      @(negedge sys_clk);
      if (bus.mmu_l1_done === 1'b1) begin done_at = cyc - t0; bus.l1_mmu_req_read = 1'b0; end
    end
    bus.l1_mmu_req_read = 1'b0;
    total++; if (done_at != 256) begin bad++; $display("FAIL timeout_latency got %0d want 256", done_at); end
    total++; if (bus.mmu_l1_read_data[31:0] !== MMIO_ERR_DATA) begin bad++; $display("FAIL timeout_data got %h want deadbeef", bus.mmu_l1_read_data[31:0]); end
    total++; if (bus.mmio_req !== 1'b0) begin bad++; $display("FAIL timeout_req got %b want 0", bus.mmio_req); end
`else
    for (int n = 1; n <= 300; n++) begin
      @(negedge sys_clk);
      if (bus.mmu_l1_done === 1'b1 && done_at < 0) done_at = cyc - t0;
    end
    total++; if (done_at >= 0) begin bad++; $display("FAIL no_timeout_done got pulse at %0d want none", done_at); end
    total++; if (bus.mmio_req !== 1'b1) begin bad++; $display("FAIL no_timeout_req got %b want 1", bus.mmio_req); end
    bus.mmio_ack = 1'b1; bus.mmio_rdata = 32'h99;
    @(negedge sys_clk);
    bus.mmio_ack = 1'b0; bus.l1_mmu_req_read = 1'b0;
    total++; if (bus.mmu_l1_done !== 1'b1 || bus.mmu_l1_read_data !== {224'b0, 32'h99}) begin
      bad++; $display("FAIL late_ack got done=%b data=%h want 1/99", bus.mmu_l1_done, bus.mmu_l1_read_data[31:0]);
    end
`endif
    repeat (3) @(negedge sys_clk);
  endtask

  initial begin
    bus.l1_mmu_req_read   = 1'b0;
    bus.l1_mmu_req_write  = 1'b0;
    bus.l1_mmu_req_addr   = 32'h0;
    bus.l1_mmu_write_data = '0;
    bus.mmio_rdata        = 32'h0;
    bus.mmio_ack          = 1'b0;
    last_rd               = '0;
    test_reset();
    test_refill();
    test_writeback();
    test_back_to_back();
    test_mmio();
    test_reset_mid_burst();
    test_mmio_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
